// File: rtl/clause_queue_pkg.sv
// clause_queue_pkg: clause type and queue sizing shared by the switch, arbiter, queue and engine.
package clause_queue_pkg;
   localparam int CLQ_DEPTH_DEFAULT = 16;
   typedef struct packed {
      logic [7:0]  id;
      logic [1:0]  kind;
      logic [21:0] lits;
   } cla_t;
endpackage

// File: rtl/clq_ptr_ctrl.sv
// clq_ptr_ctrl: pointers, occupancy, status flags and sticky overflow for clause_queue.
module clq_ptr_ctrl #(
   parameter int DEPTH = 16,
   parameter int AF_THRESH = DEPTH - 4,
   parameter int CNT_W = $clog2(DEPTH) + 1,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_req,
   input  logic             flush,
   input  logic             ready,
   output logic             wr_en,
   output logic [PTR_W-1:0] wr_ptr,
   output logic [PTR_W-1:0] rd_ptr,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             valid,
   output logic             overflow
);
   logic pop;
   // Flags come only from the registered count, so no input reaches an output combinationally.
   assign full        = count == CNT_W'(DEPTH);
   assign empty       = count == '0;
   assign valid       = !empty;
   assign almost_full = count >= CNT_W'(AF_THRESH);
   assign wr_en       = push_req && !full && !flush;
   assign pop         = ready && valid && !flush;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= overflow | (push_req && full && !flush);
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            wr_ptr <= wr_ptr + PTR_W'(wr_en);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + CNT_W'(wr_en) - CNT_W'(pop);
         end
      end
   end
endmodule

// File: rtl/clause_queue.sv
// clause_queue: show-ahead clause FIFO between the clause switch and the engine,
// with almost-full throttling, synchronous flush and sticky overflow.
module clause_queue
   import clause_queue_pkg::*;
#(
   parameter int DEPTH = CLQ_DEPTH_DEFAULT,
   parameter int AF_THRESH = DEPTH - 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      sw2clq,
   input  logic             sw2clq_valid,
   input  logic             clq_flush,
   output logic [31:0]      clq2eng,
   output logic             clq2eng_valid,
   input  logic             eng2clq_ready,
   output logic             clq_almost_full,
   output logic             clq_full,
   output logic             clq_empty,
   output logic [CNT_W-1:0] clq_count,
   output logic             clq_overflow
);
   localparam int PTR_W = $clog2(DEPTH);
   cla_t             mem [DEPTH];
   logic             wr_en;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   clq_ptr_ctrl #(.DEPTH(DEPTH), .AF_THRESH(AF_THRESH), .CNT_W(CNT_W), .PTR_W(PTR_W)) u_ctrl (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_req    (sw2clq_valid),
      .flush       (clq_flush),
      .ready       (eng2clq_ready),
      .wr_en       (wr_en),
      .wr_ptr      (wr_ptr),
      .rd_ptr      (rd_ptr),
      .count       (clq_count),
      .full        (clq_full),
      .empty       (clq_empty),
      .almost_full (clq_almost_full),
      .valid       (clq2eng_valid),
      .overflow    (clq_overflow)
   );
   // Storage carries no reset; stale entries are never visible because valid follows count.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= cla_t'(sw2clq);
   end
   assign clq2eng = mem[rd_ptr];
endmodule
